// File: rtl/evenodd_run_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : evenodd_run_monitor_if
// Description : Sample strobe / flag inputs and statistics outputs of the
//               even/odd run monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface evenodd_run_monitor_if #(
    parameter int CNT_W = 16,
    parameter int RUN_W = 4
);
    logic             sample_valid;
    logic             even;
    logic             odd;
    logic             clear;
    logic [CNT_W-1:0] even_count;
    logic [CNT_W-1:0] odd_count;
    logic [RUN_W-1:0] run_len;
    logic             run_parity;
    logic             run_alarm;
    logic             error;

    modport master (
        output sample_valid, even, odd, clear,
        input  even_count, odd_count, run_len, run_parity, run_alarm, error
    );

    modport slave (
        input  sample_valid, even, odd, clear,
        output even_count, odd_count, run_len, run_parity, run_alarm, error
    );
endinterface
`default_nettype wire

// File: rtl/evenodd_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : evenodd_run_monitor
// Description : Saturating even/odd sample counters, same-parity run tracker
//               with threshold alarm, and sticky illegal-sample error.
// Revision    : 1.0 - initial release
// ============================================================================
module evenodd_run_monitor #(
    parameter int CNT_W      = 16,
    parameter int RUN_W      = 4,
    parameter int RUN_THRESH = 4
) (
    input  wire                     clk,
    input  wire                     reset,
    evenodd_run_monitor_if.slave    bus
);

    localparam logic [1:0]       c_S_IDLE     = 2'd0;
    localparam logic [1:0]       c_S_EVEN     = 2'd1;
    localparam logic [1:0]       c_S_ODD      = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [RUN_W-1:0] c_LEN_MAX    = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] c_LEN_ONE    = RUN_W'(1);
    localparam logic [RUN_W-1:0] c_RUN_THRESH = RUN_W'(RUN_THRESH);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_even_count;
    logic [CNT_W-1:0] r_odd_count;
    logic [RUN_W-1:0] r_run_len;
    logic             r_run_parity;
    logic             r_run_alarm;
    logic             r_error;

    logic             w_legal_even;
    logic             w_legal_odd;
    logic             w_illegal;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_even_count_nxt;
    logic [CNT_W-1:0] w_odd_count_nxt;
    logic [RUN_W-1:0] w_run_len_nxt;
    logic             w_run_parity_nxt;
    logic             w_run_alarm_nxt;
    logic             w_error_nxt;

    assign w_legal_even = bus.sample_valid &  bus.even & ~bus.odd;
    assign w_legal_odd  = bus.sample_valid & ~bus.even &  bus.odd;
    assign w_illegal    = bus.sample_valid & (bus.even == bus.odd);

    always_comb begin
        w_state_nxt      = r_state;
        w_even_count_nxt = r_even_count;
        w_odd_count_nxt  = r_odd_count;
        w_run_len_nxt    = r_run_len;
        w_run_parity_nxt = r_run_parity;
        w_error_nxt      = r_error;

        if (w_legal_even) begin
            if (r_even_count != c_CNT_MAX)
                w_even_count_nxt = r_even_count + CNT_W'(1);
            if (r_state == c_S_EVEN)
                w_run_len_nxt = (r_run_len == c_LEN_MAX) ? r_run_len : r_run_len + c_LEN_ONE;
            else
                w_run_len_nxt = c_LEN_ONE;
            w_state_nxt      = c_S_EVEN;
            w_run_parity_nxt = 1'b0;
        end else if (w_legal_odd) begin
            if (r_odd_count != c_CNT_MAX)
                w_odd_count_nxt = r_odd_count + CNT_W'(1);
            if (r_state == c_S_ODD)
                w_run_len_nxt = (r_run_len == c_LEN_MAX) ? r_run_len : r_run_len + c_LEN_ONE;
            else
                w_run_len_nxt = c_LEN_ONE;
            w_state_nxt      = c_S_ODD;
            w_run_parity_nxt = 1'b1;
        end else if (w_illegal) begin
            w_error_nxt = 1'b1;
        end

        // Alarm tracks the post-edge run length; IDLE has run_len 0 < threshold.
        w_run_alarm_nxt = (w_run_len_nxt >= c_RUN_THRESH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_even_count <= '0;
            r_odd_count  <= '0;
            r_run_len    <= '0;
            r_run_parity <= 1'b0;
            r_run_alarm  <= 1'b0;
            r_error      <= 1'b0;
        end else if (bus.clear) begin
            r_state      <= c_S_IDLE;
            r_even_count <= '0;
            r_odd_count  <= '0;
            r_run_len    <= '0;
            r_run_parity <= 1'b0;
            r_run_alarm  <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_even_count <= w_even_count_nxt;
            r_odd_count  <= w_odd_count_nxt;
            r_run_len    <= w_run_len_nxt;
            r_run_parity <= w_run_parity_nxt;
            r_run_alarm  <= w_run_alarm_nxt;
            r_error      <= w_error_nxt;
        end
    end

    assign bus.even_count = r_even_count;
    assign bus.odd_count  = r_odd_count;
    assign bus.run_len    = r_run_len;
    assign bus.run_parity = r_run_parity;
    assign bus.run_alarm  = r_run_alarm;
    assign bus.error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_evenodd_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_evenodd_run_monitor
// Description : Directed vector bench for evenodd_run_monitor (default
//               parameters plus a CNT_W=4 / RUN_THRESH=1 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_evenodd_run_monitor;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    evenodd_run_monitor_if #(.CNT_W(16), .RUN_W(4)) bus1 ();
    evenodd_run_monitor_if #(.CNT_W(4),  .RUN_W(4)) bus2 ();

    evenodd_run_monitor #(.CNT_W(16), .RUN_W(4), .RUN_THRESH(4)) u_dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
    );

    evenodd_run_monitor #(.CNT_W(4), .RUN_W(4), .RUN_THRESH(1)) u_dut2 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic sv, ev, od, clr;
        int   ec, oc, len, par, al, err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string tag, input int ec, input int oc, input int len,
                        input int par, input int al, input int err);
        chk({tag, ".even_count"}, int'(bus1.even_count), ec);
        chk({tag, ".odd_count"},  int'(bus1.odd_count),  oc);
        chk({tag, ".run_len"},    int'(bus1.run_len),    len);
        chk({tag, ".run_parity"}, int'(bus1.run_parity), par);
        chk({tag, ".run_alarm"},  int'(bus1.run_alarm),  al);
        chk({tag, ".error"},      int'(bus1.error),      err);
    endtask

    task automatic chk2(input string tag, input int ec, input int oc, input int len,
                        input int par, input int al, input int err);
        chk({tag, ".even_count"}, int'(bus2.even_count), ec);
        chk({tag, ".odd_count"},  int'(bus2.odd_count),  oc);
        chk({tag, ".run_len"},    int'(bus2.run_len),    len);
        chk({tag, ".run_parity"}, int'(bus2.run_parity), par);
        chk({tag, ".run_alarm"},  int'(bus2.run_alarm),  al);
        chk({tag, ".error"},      int'(bus2.error),      err);
    endtask

    // Inputs change on the falling edge; outputs are read 1 time unit after the rising edge.
    task automatic drive1(input logic sv, input logic ev, input logic od, input logic clr);
        @(negedge clk);
        bus1.sample_valid = sv; bus1.even = ev; bus1.odd = od; bus1.clear = clr;
        @(posedge clk);
        #1;
        bus1.sample_valid = 1'b0; bus1.clear = 1'b0;
    endtask

    task automatic drive2(input logic sv, input logic ev, input logic od, input logic clr);
        @(negedge clk);
        bus2.sample_valid = sv; bus2.even = ev; bus2.odd = od; bus2.clear = clr;
        @(posedge clk);
        #1;
        bus2.sample_valid = 1'b0; bus2.clear = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus1.sample_valid = 1'b0; bus1.even = 1'b0; bus1.odd = 1'b0; bus1.clear = 1'b0;
        bus2.sample_valid = 1'b0; bus2.even = 1'b0; bus2.odd = 1'b0; bus2.clear = 1'b0;

        //          sv ev od clr  ec oc len par al err
        vecs[0]  = '{1, 1, 0, 0,   1, 0, 1, 0, 0, 0};
        vecs[1]  = '{1, 1, 0, 0,   2, 0, 2, 0, 0, 0};
        vecs[2]  = '{1, 1, 0, 0,   3, 0, 3, 0, 0, 0};
        vecs[3]  = '{1, 1, 0, 0,   4, 0, 4, 0, 1, 0};
        vecs[4]  = '{0, 1, 1, 0,   4, 0, 4, 0, 1, 0};
        vecs[5]  = '{1, 0, 1, 0,   4, 1, 1, 1, 0, 0};
        vecs[6]  = '{1, 1, 1, 0,   4, 1, 1, 1, 0, 1};
        vecs[7]  = '{1, 0, 0, 0,   4, 1, 1, 1, 0, 1};
        vecs[8]  = '{0, 1, 0, 0,   4, 1, 1, 1, 0, 1};
        vecs[9]  = '{1, 0, 1, 0,   4, 2, 2, 1, 0, 1};
        vecs[10] = '{1, 1, 0, 0,   5, 2, 1, 0, 0, 1};
        vecs[11] = '{1, 1, 0, 1,   0, 0, 0, 0, 0, 0};
        vecs[12] = '{1, 0, 1, 0,   0, 1, 1, 1, 0, 0};
        vecs[13] = '{0, 0, 0, 1,   0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset1", 0, 0, 0, 0, 0, 0);
        chk2("reset2", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive1(vecs[i].sv, vecs[i].ev, vecs[i].od, vecs[i].clr);
            chk1($sformatf("vec%0d", i), vecs[i].ec, vecs[i].oc, vecs[i].len,
                 vecs[i].par, vecs[i].al, vecs[i].err);
        end

        // Asynchronous reset in the middle of an odd run of length 3.
        drive1(1, 0, 1, 0);
        drive1(1, 0, 1, 0);
        drive1(1, 0, 1, 0);
        chk1("pre_reset", 0, 3, 3, 1, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk1("async_reset", 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        drive1(1, 1, 0, 0);
        chk1("post_reset", 1, 0, 1, 0, 0, 0);

        // Run-length saturation over 20 odd samples.
        drive1(0, 0, 0, 1);
        chk1("clear", 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            drive1(1, 0, 1, 0);
            chk1($sformatf("odd_run%0d", i), 0, i, (i > 15) ? 15 : i, 1, (i >= 4) ? 1 : 0, 0);
        end

        // Threshold of 1 alarms on the first sample and stays up across a run break.
        drive2(1, 0, 1, 0);
        chk2("t1_odd", 0, 1, 1, 1, 1, 0);
        drive2(1, 1, 0, 0);
        chk2("t1_break", 1, 1, 1, 0, 1, 0);

        // 4-bit counter saturation over 17 even samples.
        drive2(0, 0, 0, 1);
        chk2("t1_clear", 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            drive2(1, 1, 0, 0);
            chk2($sformatf("even_sat%0d", i), (i > 15) ? 15 : i, 0, (i > 15) ? 15 : i, 0, 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/evenodd_run_monitor.md
# evenodd_run_monitor

Downstream statistics stage for the even/odd classifier. It samples the classifier's `even`/`odd` flags on a strobe and keeps saturating even and odd counts. It also tracks the current run of same-parity samples and raises an alarm when a run reaches a programmable length. Illegal flag combinations set a sticky error.

## Interface

- `CNT_W`, default 16: width of the even and odd sample counters.
- `RUN_W`, default 4: width of the run-length counter.
- `RUN_THRESH`, default 4: run length at which `run_alarm` asserts. Legal range is 1 to 2^RUN_W-1.

Ports:
- `clk`  input  1: single clock, all logic on its rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `sample_valid`  input  1: high for one cycle when `even`/`odd` hold a fresh classification. The top level drives it as the classifier's `in_valid` delayed by one cycle.
- `even`  input  1: classifier even flag.
- `odd`  input  1: classifier odd flag.
- `clear`  input  1: synchronous clear of all counters, state and error.
- `even_count`  output  CNT_W: number of legal even samples, saturating.
- `odd_count`  output  CNT_W: number of legal odd samples, saturating.
- `run_len`  output  RUN_W: length of the current same-parity run, saturating.
- `run_parity`  output  1: parity of the current run (0 = even, 1 = odd). 0 in IDLE.
- `run_alarm`  output  1: high while `run_len` >= RUN_THRESH.
- `error`  output  1: sticky; set by an illegal sample.

## Operation

- **Sample classes:** a sample is a cycle with `sample_valid`=1.
  - Legal even: `even`=1, `odd`=0.
  - Legal odd: `even`=0, `odd`=1.
  - Illegal: `even`==`odd`, either both 0 or both 1.
- **FSM states:** IDLE, EVEN_RUN, ODD_RUN. State encoding is implementation choice; `run_parity` is 1 only in ODD_RUN.
  - IDLE, legal even -> EVEN_RUN, `run_len`=1.
  - IDLE, legal odd -> ODD_RUN, `run_len`=1.
  - EVEN_RUN, legal even -> stay, `run_len`+1 (saturating).
  - EVEN_RUN, legal odd -> ODD_RUN, `run_len`=1.
  - ODD_RUN mirrors EVEN_RUN.
  - Any state, illegal sample -> state, `run_len` and counters unchanged; `error` set to 1.
  - Any state, `clear`=1 -> IDLE.
- **Counters:**
  - A legal even sample increments `even_count`; a legal odd sample increments `odd_count`.
  - Both counters stick at 2^CNT_W-1, with no wrap-around.
  - `run_len` sticks at 2^RUN_W-1; the FSM stays in its run state.
- **Alarm:**
  - `run_alarm` is registered and updated on the same edge as `run_len`, from the new `run_len` value.
  - It deasserts on the edge where the run breaks (`run_len` returns to 1), unless RUN_THRESH=1.
- **No sample** (`sample_valid`=0): all outputs hold. `even`/`odd` are don't-care.
- **Clear:**
  - `clear`=1 zeros `even_count`, `odd_count`, `run_len`, `run_parity`, `run_alarm` and `error`, and returns the FSM to IDLE.
  - `clear` has priority over a simultaneous sample; that sample is discarded.
- **Error:** `error` is cleared only by `clear` or `reset`. Legal samples after an error are still processed normally.

## Timing

- **Reset:** `reset` high asynchronously forces all outputs to 0 and the FSM to IDLE, including mid-run or with `sample_valid` high. The first sample is accepted on the first rising edge with `reset` low.
- **Latency:** one cycle. A sample presented before edge N is reflected on all outputs immediately after edge N.
- **Throughput:** one sample per cycle. Back-to-back `sample_valid` pulses are fully supported.
- **Registered outputs:** all outputs are flop outputs; there are no combinational paths from inputs to outputs.

## Test plan

- **Reset:** assert `reset` asynchronously mid-cycle during an odd run with `run_len`=3 -> all outputs read 0 before the next edge; the next sample is an even -> `run_len`=1, `run_parity`=0.
- **Even run:** 4 back-to-back even samples -> `run_len` reads 1,2,3,4, `even_count`=4. `run_alarm` rises after the 4th edge. A following idle cycle holds all values.
- **Run break:** samples E,E,E,E,O -> after the O sample, `run_len`=1, `run_parity`=1, `run_alarm`=0, `even_count`=4, `odd_count`=1.
- **Illegal sample and clear:** sample with `even`=1, `odd`=1 -> `error`=1 and counters unchanged. A later legal odd still counts. Then `clear` together with `sample_valid`=1 -> all outputs 0, FSM in IDLE, sample discarded.
- **Run saturation:** 20 consecutive odd samples -> `run_len` saturates at 15, `run_alarm` stays 1, `odd_count`=20.
- **Counter saturation:** with `CNT_W`=4, 17 even samples -> `even_count`=15 (no wrap). With `RUN_THRESH`=1, a single odd sample -> `run_alarm`=1.
